muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL provide: rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL provide: start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL provide: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL provide: srcA  input  32  multiplicand / dividend.
REQ-006 SHALL provide: srcB  input  32  multiplier / divisor.
REQ-007 SHALL provide: cancel  input  1  abort the in-flight operation; no HI/LO write.
REQ-008 SHALL provide: busy  output  1  high in states CALC and FIX.
REQ-009 SHALL provide: done  output  1  one-cycle pulse; result valid on hiWtData/loWtData.
REQ-010 SHALL provide: hiWtCe  output  1  HI write enable; same cycle as done.
REQ-011 SHALL provide: loWtCe  output  1  LO write enable; same cycle as done.
REQ-012 SHALL provide: hiWtData  output  32  HI result: product[63:32] or remainder.
REQ-013 SHALL provide: loWtData  output  32  LO result: product[31:0] or quotient.
REQ-014 SHALL provide: divZero  output  1  high with done when a DIV/DIVU had srcB == 0.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX; the 5-bit iteration counter SHALL be zero in IDLE.
REQ-016 IDLE with start=1, cancel=0 at edge E0: SHALL latch op, srcA, srcB (later input changes ignored), clear the counter, and enter CALC.
REQ-017 Signed ops SHALL iterate on operand magnitudes and record the result signs at E0.
REQ-018 CALC SHALL perform one radix-2 step per edge: shift-add for multiply, restoring shift-subtract for divide; the counter SHALL increment each step.
REQ-019 The step at counter 31 (edge E32) SHALL move CALC to FIX.
REQ-020 FIX at E33 SHALL apply sign correction, register results, pulse done/hiWtCe/loWtCe for exactly one cycle, and return to IDLE.
REQ-021 Nominal latency: start sampled at E0 -> done high in the cycle after E33 (34 cycles).
REQ-022 MULT/MULTU SHALL produce the exact 64-bit two's-complement / unsigned product.
REQ-023 DIV SHALL truncate toward zero: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no flag.
REQ-025 DIV/DIVU with srcB == 0 SHALL go IDLE -> FIX at E0, skipping CALC.
REQ-026 Divide-by-zero FIX at E1 SHALL drive HI=srcA, LO=0xFFFFFFFF, divZero=1 with done (2-cycle latency).
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 start in the done cycle (state IDLE) SHALL be accepted back-to-back.
REQ-029 cancel=1 in CALC or FIX SHALL return to IDLE at the next edge with no done, no write enables, and outputs unchanged.
REQ-030 cancel=1 together with start in IDLE SHALL take priority; start is ignored.
REQ-031 cancel and FIX completion at the same edge: cancel SHALL win (no write).
REQ-032 busy SHALL be low in the done cycle.
REQ-033 hiWtData/loWtData SHALL hold the last results between operations.
REQ-034 divZero SHALL be high only in the done cycle.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, counter 0, and busy, done, hiWtCe, loWtCe, divZero, hiWtData, loWtData all to 0, including mid-operation.
REQ-036 Release of rst SHALL be followed by no spurious done; the first start is accepted at the first edge with rst=1.

Verification
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 34 cycles after start; HI=0xFFFFFFFE, LO=0x00000001; both write enables high for 1 cycle.
REQ-038 MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-039 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF issued in the done cycle -> LO=0x80000000, HI=0.
REQ-040 DIVU 0x00000064 / 0 -> done 2 cycles after start; HI=0x00000064, LO=0xFFFFFFFF, divZero=1.
REQ-041 MULTU started, cancel at counter 10 -> no done or write for 40 cycles, busy low; a new start is accepted immediately.
REQ-042 rst=0 pulsed mid-CALC -> all outputs 0 without waiting for a clock edge, and no done after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply / 32/32 divide unit with HI/LO write-back.
// A single 64-bit accumulator holds the shifting product, or {remainder, quotient} for divides.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        hiWtCe,
  output logic        loWtCe,
  output logic [31:0] hiWtData,
  output logic [31:0] loWtData,
  output logic        divZero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opr_q, opr_d;
  logic        is_div_q, is_div_d;
  logic        neg_hi_q, neg_hi_d;
  logic        neg_lo_q, neg_lo_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;
  logic        dz_out_q, dz_out_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] acc_neg;
  logic [31:0] hi_neg, lo_neg;

  // op[0] clear selects the signed flavour of both multiply and divide
  assign a_neg    = ~op[0] & srcA[31];
  assign b_neg    = ~op[0] & srcB[31];
  assign a_mag    = a_neg ? 32'd0 - srcA : srcA;
  assign b_mag    = b_neg ? 32'd0 - srcB : srcB;
  assign div_zero = op[1] & (srcB == 32'd0);

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // restoring step: partial remainder shifted left with next dividend bit
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_shift >= {1'b0, opr_q};
  assign div_sub   = div_shift[31:0] - opr_q;
  assign div_next  = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                            : {div_shift[31:0], acc_q[30:0], 1'b0};

  assign acc_neg = 64'd0 - acc_q;
  assign hi_neg  = 32'd0 - acc_q[63:32];
  assign lo_neg  = 32'd0 - acc_q[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !cancel) state_d = div_zero ? S_FIX : S_CALC;
      S_CALC: begin
        if (cancel)                state_d = S_IDLE;
        else if (cnt_q == 5'd31)   state_d = S_FIX;
      end
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dz_out_d = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 5'd0;
        if (start && !cancel) begin
          is_div_d = op[1];
          dz_d     = div_zero;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = op[1] ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            // divide-by-zero result is preloaded so FIX passes it through untouched
            acc_d    = {srcA, 32'hFFFF_FFFF};
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
          end else if (op[1]) begin
            acc_d = {32'd0, a_mag};
            opr_d = b_mag;
          end else begin
            acc_d = {32'd0, b_mag};
            opr_d = a_mag;
          end
        end
      end
      S_CALC: begin
        if (cancel) begin
          cnt_d = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
          acc_d = is_div_q ? div_next : mul_next;
        end
      end
      S_FIX: begin
        cnt_d = 5'd0;
        if (!cancel) begin
          done_d   = 1'b1;
          dz_out_d = dz_q;
          if (is_div_q) begin
            hi_d = neg_hi_q ? hi_neg : acc_q[63:32];
            lo_d = neg_lo_q ? lo_neg : acc_q[31:0];
          end else begin
            {hi_d, lo_d} = neg_lo_q ? acc_neg : acc_q;
          end
        end
      end
      default: cnt_d = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opr_q    <= 32'd0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      dz_out_q <= dz_out_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done     = done_q;
  assign hiWtCe   = done_q;
  assign loWtCe   = done_q;
  assign hiWtData = hi_q;
  assign loWtData = lo_q;
  assign divZero  = dz_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        busy, done, hiWtCe, loWtCe, divZero;
  logic [31:0] hiWtData, loWtData;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  typedef struct {
    bit          seen;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        hce;
    logic        lce;
    logic        busy_done;
    bit          stray;
  } obs_t;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .cancel(cancel), .busy(busy), .done(done), .hiWtCe(hiWtCe), .loWtCe(loWtCe),
    .hiWtData(hiWtData), .loWtData(loWtData), .divZero(divZero)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    if (o == 2'd0) begin
      p = 64'(sa * sb);
      hi = p[63:32]; lo = p[31:0];
    end else if (o == 2'd1) begin
      p = {32'd0, a} * {32'd0, b};
      hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
    end else if (o == 2'd2) begin
      q = sa / sb; r = sa % sb;
      lo = q[31:0]; hi = r[31:0];
    end else begin
      lo = a / b; hi = a % b;
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
  endtask

  // waits for done while scrambling inputs; optionally issues the next op in the done cycle
  task automatic observe(input bit chain, input logic [1:0] no, input logic [31:0] na,
                         input logic [31:0] nb, output obs_t r);
    r.seen = 0; r.lat = 0; r.hi = '0; r.lo = '0; r.dz = 0;
    r.hce = 0; r.lce = 0; r.busy_done = 0; r.stray = 0;
    for (int n = 1; n <= 40 && !r.seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        r.seen = 1; r.lat = n; r.hi = hiWtData; r.lo = loWtData; r.dz = divZero;
        r.hce = hiWtCe; r.lce = loWtCe; r.busy_done = busy;
        if (chain) begin start = 1'b1; op = no; srcA = na; srcB = nb; end
        else start = 1'b0;
      end else begin
        if (busy !== 1'b1 || hiWtCe !== 1'b0 || loWtCe !== 1'b0 || divZero !== 1'b0) r.stray = 1;
        start = 1'($urandom_range(0, 1)); op = 2'($urandom); srcA = $urandom; srcB = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    obs_t r;
    logic [31:0] a, b, eh, el;
    logic edz;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, hiWtCe, loWtCe, divZero} !== 5'b0 || hiWtData !== 32'd0 || loWtData !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b ce=%b%b dz=%b hi=%h lo=%h required all zero",
               busy, done, hiWtCe, loWtCe, divZero, hiWtData, loWtData);
    end
    @(negedge clk);
    @(negedge clk);
    a = $urandom; b = $urandom;
    rst = 1'b1; start = 1'b1; op = 2'd1; srcA = a; srcB = b;
    observe(0, 2'd0, 32'd0, 32'd0, r);
    ref_model(2'd1, a, b, eh, el, edz);
    checks++;
    if (!r.seen || r.lat != 34 || r.hi !== eh || r.lo !== el) begin
      errors++;
      $display("FAIL first_start_after_reset lat=%0d hi=%h lo=%h required lat=34 hi=%h lo=%h",
               r.lat, r.hi, r.lo, eh, el);
    end
    last_hi = eh; last_lo = el;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0064};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] hs  [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0064};
    logic [31:0] ls  [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    bit          ch  [5] = '{0, 0, 1, 0, 0};
    obs_t r;
    for (int i = 0; i < 5; i++) begin
      int  elat;
      bit  edz;
      elat = (ops[i][1] && bs[i] == 32'd0) ? 2 : 34;
      edz  = (ops[i][1] && bs[i] == 32'd0);
      if (!(i > 0 && ch[i-1])) start_op(ops[i], as[i], bs[i]);
      if (ch[i]) observe(1, ops[i+1], as[i+1], bs[i+1], r);
      else       observe(0, 2'd0, 32'd0, 32'd0, r);
      checks++;
      if (!r.seen || r.lat != elat) begin
        errors++; $display("FAIL directed%0d_latency got %0d required %0d", i, r.lat, elat);
      end
      checks++;
      if (r.hi !== hs[i] || r.lo !== ls[i]) begin
        errors++; $display("FAIL directed%0d_result hi=%h lo=%h required hi=%h lo=%h", i, r.hi, r.lo, hs[i], ls[i]);
      end
      checks++;
      if (r.dz !== edz) begin
        errors++; $display("FAIL directed%0d_divzero got %b required %b", i, r.dz, edz);
      end
      checks++;
      if ({r.hce, r.lce} !== 2'b11 || r.busy_done !== 1'b0) begin
        errors++; $display("FAIL directed%0d_done_cycle ce=%b%b busy=%b required ce=11 busy=0", i, r.hce, r.lce, r.busy_done);
      end
      checks++;
      if (r.stray) begin
        errors++; $display("FAIL directed%0d_busy_window got stray=1 required stray=0", i);
      end
      last_hi = hs[i]; last_lo = ls[i];
      if (!ch[i]) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || divZero !== 1'b0 || hiWtData !== hs[i] || loWtData !== ls[i]) begin
          errors++;
          $display("FAIL directed%0d_after_done done=%b dz=%b hi=%h lo=%h required done=0 dz=0 hi=%h lo=%h",
                   i, done, divZero, hiWtData, loWtData, hs[i], ls[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t r;
    logic [1:0]  co, no;
    logic [31:0] ca, cb, na, nb, eh, el;
    logic        edz;
    bit          ch;
    co = 2'($urandom); ca = gen_operand(); cb = gen_operand();
    start_op(co, ca, cb);
    for (int i = 0; i < 30; i++) begin
      no = 2'($urandom); na = gen_operand(); nb = gen_operand();
      ch = (i < 29) && ($urandom_range(0, 1) == 1);
      observe(ch, no, na, nb, r);
      ref_model(co, ca, cb, eh, el, edz);
      checks++;
      if (!r.seen || r.lat != ((co[1] && cb == 32'd0) ? 2 : 34) || r.hi !== eh || r.lo !== el ||
          r.dz !== edz || r.stray || {r.hce, r.lce} !== 2'b11) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h dz=%b stray=%0d required hi=%h lo=%h dz=%b",
                 i, co, ca, cb, r.lat, r.hi, r.lo, r.dz, r.stray, eh, el, edz);
      end
      last_hi = eh; last_lo = el;
      if (i < 29 && !ch) start_op(no, na, nb);
      co = no; ca = na; cb = nb;
    end
  endtask

  task automatic test_cancel();
    obs_t r;
    logic [31:0] a, b, eh, el;
    logic edz;
    bit bad;
    // cancel while the counter reads 10
    start_op(2'd1, $urandom, $urandom);
    repeat (11) begin @(negedge clk); start = 1'b0; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL cancel_calc_busy got %b required 1", busy); end
    cancel = 1'b1;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cancel = 1'b0;
      if (done !== 1'b0 || hiWtCe !== 1'b0 || loWtCe !== 1'b0 || busy !== 1'b0 ||
          hiWtData !== last_hi || loWtData !== last_lo) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL cancel_calc_quiet got activity hi=%h lo=%h required none hi=%h lo=%h",
                         hiWtData, loWtData, last_hi, last_lo);
    end
    a = $urandom; b = $urandom;
    start = 1'b1; op = 2'd2; srcA = a; srcB = b;
    observe(0, 2'd0, 32'd0, 32'd0, r);
    ref_model(2'd2, a, b, eh, el, edz);
    checks++;
    if (!r.seen || r.lat != 34 || r.hi !== eh || r.lo !== el) begin
      errors++; $display("FAIL cancel_restart lat=%0d hi=%h lo=%h required lat=34 hi=%h lo=%h", r.lat, r.hi, r.lo, eh, el);
    end
    last_hi = eh; last_lo = el;
    // cancel lands on the FIX completion edge
    start_op(2'd0, $urandom, $urandom);
    repeat (33) begin @(negedge clk); start = 1'b0; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL cancel_fix_busy got %b required 1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (done !== 1'b0 || hiWtCe !== 1'b0 || loWtCe !== 1'b0 || busy !== 1'b0 ||
        hiWtData !== last_hi || loWtData !== last_lo) begin
      errors++; $display("FAIL cancel_fix done=%b ce=%b%b busy=%b hi=%h lo=%h required 0 00 0 hi=%h lo=%h",
                         done, hiWtCe, loWtCe, busy, hiWtData, loWtData, last_hi, last_lo);
    end
    // cancel together with start in IDLE
    start = 1'b1; cancel = 1'b1; op = 2'd3; srcA = $urandom; srcB = 32'd0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    bad = (busy !== 1'b0);
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || divZero !== 1'b0 || hiWtData !== last_hi) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL cancel_with_start got activity required none"); end
  endtask

  task automatic test_reset_mid();
    bit bad;
    start_op(2'd0, $urandom, $urandom);
    repeat (15) begin @(negedge clk); start = 1'b0; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, hiWtCe, loWtCe, divZero} !== 5'b0 || hiWtData !== 32'd0 || loWtData !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b ce=%b%b dz=%b hi=%h lo=%h required all zero",
               busy, done, hiWtCe, loWtCe, divZero, hiWtData, loWtData);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || hiWtCe !== 1'b0 || busy !== 1'b0 || hiWtData !== 32'd0 || loWtData !== 32'd0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_mid_release got activity required none"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
